div_repeated_sub: RTL and testbench
===================================

DIV_REPEATED_SUB -- requirements
Module: div_repeated_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; level-sampled on rising edge.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned numerator, sampled with start.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned denominator, sampled with start.
REQ-007 SHALL have port quotient  output  WIDTH  registered unsigned result.
REQ-008 SHALL have port remainder  output  WIDTH  registered unsigned result.
REQ-009 SHALL have port busy  output  1  high in CHECK and SUB.
REQ-010 SHALL have port done  output  1  high in DONE.
REQ-011 SHALL have port div_by_zero  output  1  error flag, valid while done=1.

Function
REQ-012 SHALL implement an FSM with states IDLE, CHECK, SUB, DONE; all outputs registered or decoded from state only.
REQ-013 SHALL hold internal registers A (running remainder), B (divisor), Q (count), each WIDTH bits.
REQ-014 IDLE: on start=1, SHALL load A<=dividend, B<=divisor, Q<=0, and go to CHECK; otherwise stay.
REQ-015 CHECK: if B==0, SHALL go to DONE with div_by_zero<=1, quotient<={WIDTH{1}}, remainder<=A; else go to SUB.
REQ-016 SUB: if A>=B, SHALL perform A<=A-B and Q<=Q+1 and stay in SUB; else SHALL go to DONE with quotient<=Q, remainder<=A, div_by_zero<=0.
REQ-017 Comparison and subtraction SHALL be unsigned WIDTH-bit; A never underflows because subtraction occurs only when A>=B.
REQ-018 Q SHALL not overflow: maximum quotient equals dividend (divisor=1), which fits in WIDTH bits.
REQ-019 Latency: with the edge sampling start numbered 0, done SHALL assert after edge q+2 for nonzero divisor (q = quotient), and after edge 1 for divisor 0.
REQ-020 DONE: SHALL hold done=1 and results stable while start=1; SHALL go to IDLE on the first edge with start=0.
REQ-021 start SHALL be ignored in CHECK and SUB; operands changing during busy SHALL not affect the result.
REQ-022 quotient, remainder, div_by_zero SHALL update only on entry to DONE and hold their values through IDLE until the next completion.
REQ-023 Holding start high continuously SHALL not re-trigger: a new operation requires start low for at least one edge in DONE and then high in IDLE.
REQ-024 busy and done SHALL never be high simultaneously; both low in IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE and set A, B, Q, quotient, remainder to 0 and busy, done, div_by_zero to 0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL abort it with no partial result visible; first start after rst_n release SHALL begin a fresh operation.
REQ-027 Deassertion of rst_n SHALL take effect at the next rising clk edge; no start sampled before then.

Verification
REQ-028 WIDTH=16, dividend=100, divisor=7, start pulsed -> busy 1, done after edge 16, quotient=14, remainder=2, div_by_zero=0.
REQ-029 dividend=5, divisor=9 -> done after edge 2, quotient=0, remainder=5; dividend=0, divisor=3 -> quotient=0, remainder=0.
REQ-030 dividend=9, divisor=0 -> done after edge 1, div_by_zero=1, quotient=16'hFFFF, remainder=9.
REQ-031 dividend=65535, divisor=1 -> done after edge 65537, quotient=65535, remainder=0 (counter-width boundary).
REQ-032 rst_n pulled low during SUB of 100/7 -> outputs 0 immediately, state IDLE; subsequent 20/6 -> quotient=3, remainder=2.
REQ-033 start held high through completion, operands changed while busy -> single result from originally sampled operands, done held, no restart until start drops.

Source files
------------

// File: rtl/div_repeated_sub.sv
// div_repeated_sub: unsigned divider by repeated subtraction, one subtraction per clock
module div_repeated_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, CHECK, SUB, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a, b, q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? CHECK : IDLE;
      CHECK:   state_nx = (b == '0) ? DONE : SUB;
      SUB:     state_nx = (a >= b) ? SUB : DONE;
      DONE:    state_nx = start ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // results change only on entry to DONE and otherwise hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      q <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a <= dividend;
          b <= divisor;
          q <= '0;
        end
        CHECK: if (b == '0) begin
          quotient <= '1;
          remainder <= a;
          div_by_zero <= 1'b1;
        end
        SUB: if (a >= b) begin
          a <= a - b;
          q <= q + WIDTH'(1);
        end else begin
          quotient <= q;
          remainder <= a;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  assign busy = (state == CHECK) || (state == SUB);
  assign done = (state == DONE);
endmodule

// File: tb/tb_div_repeated_sub.sv
// tb_div_repeated_sub: scoreboard bench for div_repeated_sub (latency, results, reset, start hold)
module tb_div_repeated_sub;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0, quotient, remainder;
  logic busy, done, div_by_zero;
  int checks = 0, errors = 0;
  typedef struct {logic [15:0] q; logic [15:0] r; logic dz; int lat;} exp_t;
  exp_t sb[$];

  div_repeated_sub #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // called at a negedge with the DUT idle; returns at the negedge where done is first seen
  task automatic run_op(input logic [15:0] dd, input logic [15:0] dv, input bit hold, input int bound);
    exp_t e;
    int n;
    e.q = (dv == 0) ? 16'hFFFF : dd / dv;
    e.r = (dv == 0) ? dd : dd % dv;
    e.dz = (dv == 0);
    e.lat = (dv == 0) ? 1 : int'(e.q) + 2;
    sb.push_back(e);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_start %0d/%0d: busy=%b done=%b required busy=1 done=0", dd, dv, busy, done);
    end
    if (!hold) start = 1'b0;
    dividend = 16'($urandom); divisor = 16'($urandom);
    while (done !== 1'b1 && n < bound) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (busy === 1'b1 && done === 1'b1) begin
        checks++; errors++;
        $display("FAIL busy_and_done %0d/%0d at edge %0d", dd, dv, n);
      end
    end
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || n != e.lat) begin
      errors++;
      $display("FAIL latency %0d/%0d: done=%b after edge %0d, required done=1 after edge %0d", dd, dv, done, n, e.lat);
    end
    checks++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz || busy !== 1'b0) begin
      errors++;
      $display("FAIL result %0d/%0d: q=%0d r=%0d dz=%b busy=%b, required q=%0d r=%0d dz=%b busy=0",
               dd, dv, quotient, remainder, div_by_zero, busy, e.q, e.r, e.dz);
    end
  endtask

  // drop start, one edge to IDLE, results must be retained
  task automatic finish_op(input logic [15:0] eq, input logic [15:0] er);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== eq || remainder !== er) begin
      errors++;
      $display("FAIL idle_hold: done=%b busy=%b q=%0d r=%0d, required done=0 busy=0 q=%0d r=%0d",
               done, busy, quotient, remainder, eq, er);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (quotient !== 16'd0 || remainder !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: q=%h r=%h busy=%b done=%b dz=%b, required all 0", quotient, remainder, busy, done, div_by_zero);
    end
    start = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: busy=%b done=%b, required 0 0", busy, done);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op(16'd100, 16'd7, 1'b0, 100); finish_op(16'd14, 16'd2);
    run_op(16'd5, 16'd9, 1'b0, 100);   finish_op(16'd0, 16'd5);
    run_op(16'd0, 16'd3, 1'b0, 100);   finish_op(16'd0, 16'd0);
    run_op(16'd9, 16'd0, 1'b0, 100);   finish_op(16'hFFFF, 16'd9);
    run_op(16'd21, 16'd7, 1'b0, 100);  finish_op(16'd3, 16'd0);
    run_op(16'd7, 16'd7, 1'b0, 100);   finish_op(16'd1, 16'd0);
  endtask

  task automatic test_hold_start();
    run_op(16'd50, 16'd12, 1'b1, 100);
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || quotient !== 16'd4 || remainder !== 16'd2) begin
      errors++;
      $display("FAIL hold_done: done=%b busy=%b q=%0d r=%0d, required done=1 busy=0 q=4 r=2", done, busy, quotient, remainder);
    end
    finish_op(16'd4, 16'd2);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    run_op(16'd1000, 16'd999, 1'b0, 100);
    finish_op(16'd1, 16'd1);
    run_op(16'd1, 16'd2, 1'b0, 100);
    finish_op(16'd0, 16'd1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (quotient !== 16'd0 || remainder !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: q=%0d r=%0d busy=%b done=%b dz=%b, required all 0", quotient, remainder, busy, done, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd20, 16'd6, 1'b0, 100);
    finish_op(16'd3, 16'd2);
  endtask

  task automatic test_max();
    run_op(16'd65535, 16'd1, 1'b0, 70000);
    finish_op(16'd65535, 16'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_start();
    test_back_to_back();
    test_reset_mid();
    test_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
